wm_sequencer: RTL

Sequencing controller for the keyed watermark generator. It owns an 8-bit LFSR and seeds it from the 8-bit key on a start request. It runs a programmable warm-up, then streams one 2-bit watermark symbol per pixel to the embedding datapath over a valid/ready handshake. It counts pixels per frame and signals frame completion to the top-level image controller.

---
 rtl/wm_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/wm_sequencer.sv
// Keyed watermark sequencer: seeds an 8-bit LFSR from key, runs WARMUP steps, then streams one symbol per pixel.
// Optional build macro WM_ROW_RESEED_EN reseeds the LFSR from seed ^ row_index at every row boundary.
module wm_sequencer #(
  parameter int WARMUP       = 16,
  parameter int FRAME_PIXELS = 4096,
  parameter int ROW_PIXELS   = 64,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] key,
  input  logic       WM_select,
  output logic       wm_valid,
  input  logic       wm_ready,
  output logic [1:0] WM_Data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WARM, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(FRAME_PIXELS - 1);

  state_t           state_q, state_d;
  logic [7:0]       q_q, q_d;
  logic [7:0]       seed_q, seed_d;
  logic [CNT_W-1:0] warm_q, warm_d;
  logic [CNT_W-1:0] pix_q, pix_d;

`ifdef WM_ROW_RESEED_EN
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_PIXELS - 1);
  logic [CNT_W-1:0] col_q, col_d;
  logic [7:0]       row_q, row_d;
`endif

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // An all-zero LFSR would never leave zero, so it is replaced.
  function automatic logic [7:0] eff_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'hA5 : s;
  endfunction

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    seed_d  = seed_q;
    warm_d  = warm_q;
    pix_d   = pix_q;
`ifdef WM_ROW_RESEED_EN
    col_d   = col_q;
    row_d   = row_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          seed_d  = key;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        q_d     = eff_seed(seed_q);
        warm_d  = '0;
        pix_d   = '0;
`ifdef WM_ROW_RESEED_EN
        col_d   = '0;
        row_d   = '0;
`endif
        state_d = (WARMUP > 0) ? S_WARM : S_RUN;
      end
      S_WARM: begin
        q_d    = lfsr_step(q_q);
        warm_d = warm_q + 1'b1;
        if (warm_q == WARM_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (wm_ready) begin
          pix_d = pix_q + 1'b1;
          q_d   = lfsr_step(q_q);
`ifdef WM_ROW_RESEED_EN
          // Row boundary (but not frame end): restart from seed ^ completed-row count.
          if (col_q == ROW_LAST && pix_q != PIX_LAST) begin
            row_d = row_q + 8'd1;
            col_d = '0;
            q_d   = eff_seed(seed_q ^ (row_q + 8'd1));
          end else begin
            col_d = col_q + 1'b1;
          end
`endif
          if (pix_q == PIX_LAST) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= 8'h00;
      seed_q  <= 8'h00;
      warm_q  <= '0;
      pix_q   <= '0;
`ifdef WM_ROW_RESEED_EN
      col_q   <= '0;
      row_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      seed_q  <= seed_d;
      warm_q  <= warm_d;
      pix_q   <= pix_d;
`ifdef WM_ROW_RESEED_EN
      col_q   <= col_d;
      row_q   <= row_d;
`endif
    end
  end

  assign wm_valid = (state_q == S_RUN);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign WM_Data  = {WM_select & (q_q[1] ^ q_q[0]), q_q[0]};

endmodule
